dmem_port_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 (cpu, load/store path) and port 1 (display/sprite fetcher reading game state).
- Sits between the requesters and the dmem syncram, and serialises their accesses.
- Handles the memory's fixed read latency and returns read data with a valid strobe.
- Runs on the dmem clock domain.

---
 rtl/dmem_port_arbiter_if.sv | 45 ++++
 rtl/dmem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
//   Bundles the two requester ports and the dmem syncram connection that
//   dmem_port_arbiter serialises.
//   Port 0 (cpu):     req0, we0, addr0, wdata0 -> gnt0, rvalid0, rdata0
//   Port 1 (display): req1, we1, addr1, wdata1 -> gnt1, rvalid1, rdata1
//   Memory side:      mem_address, mem_data, mem_wren -> dmem; mem_q <- dmem
//   Modports: slave  = arbiter view
//             master = environment view (requesters plus syncram)
interface dmem_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_q,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           mem_address, mem_data, mem_wren
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_q,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port dmem syncram between port 0 (cpu load/store) and
//   port 1 (display/sprite fetcher). One access at a time:
//   IDLE -> ISSUE -> (write) IDLE
//   IDLE -> ISSUE -> WAIT x RD_LAT -> RESP -> IDLE   (read)
//   Ports:
//     clock  - dmem clock
//     reset  - synchronous, active-low
//     bus    - dmem_port_arbiter_if.slave (requester ports + syncram side)
//     busy   - high whenever the state is not IDLE
//   Parameters: AW address width, DW data width, RD_LAT syncram read
//   latency (1..4).
//   Optional macro DMEM_ARB_RR_EN: round-robin arbitration between the two
//   ports; when undefined, port 0 has fixed priority.
module dmem_port_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_port_arbiter_if.slave   bus,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int CW = 2;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          win;

`ifdef DMEM_ARB_RR_EN
  // ptr_q names the port that wins a tie; it flips away from each winner.
  logic          ptr_q, ptr_d;

  always_comb begin
    if (bus.req0 && bus.req1) win = ptr_q;
    else                      win = bus.req1;
  end
`else
  always_comb begin
    win = !bus.req0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef DMEM_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d = win;
          addr_d  = win ? bus.addr1  : bus.addr0;
          data_d  = win ? bus.wdata1 : bus.wdata0;
          we_d    = win ? bus.we1    : bus.we0;
          state_d = S_ISSUE;
`ifdef DMEM_ARB_RR_EN
          ptr_d   = !win;
`endif
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CW'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        // q is valid in the last WAIT cycle, RD_LAT cycles after ISSUE.
        if (cnt_q == '0) begin
          if (owner_q) rdata1_d = bus.mem_q;
          else         rdata0_d = bus.mem_q;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef DMEM_ARB_RR_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // Strobes decode directly from the registered state, so they are glitch
  // free and all zero while in IDLE (including straight after reset).
  assign bus.gnt0        = (state_q == S_ISSUE) && !owner_q;
  assign bus.gnt1        = (state_q == S_ISSUE) &&  owner_q;
  assign bus.rvalid0     = (state_q == S_RESP)  && !owner_q;
  assign bus.rvalid1     = (state_q == S_RESP)  &&  owner_q;
  assign bus.mem_wren    = (state_q == S_ISSUE) &&  we_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data    = data_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter #(
  parameter int RD_LAT = 1
);
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk;
  logic rst_n;
  logic busy;

  dmem_port_arbiter_if #(.AW(AW), .DW(DW)) bif ();

  dmem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bif),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Syncram model: address registered when a read is issued, q valid
  // RD_LAT cycles after ISSUE; random garbage on q in every other cycle.
  logic [DW-1:0] mem [4096];
  logic [AW-1:0] pa [RD_LAT];
  logic          pv [RD_LAT];
  logic [DW-1:0] garbage;

  always @(posedge clk) begin
    if (bif.mem_wren) mem[bif.mem_address] <= bif.mem_data;
    pv[0] <= (bif.gnt0 || bif.gnt1) && !bif.mem_wren;
    pa[0] <= bif.mem_address;
    for (int i = 1; i < RD_LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    garbage <= $urandom;
  end

  assign bif.mem_q = pv[RD_LAT-1] ? mem[pa[RD_LAT-1]] : garbage;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_rd0, exp_rd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drop_reqs();
    bif.req0 = 1'b0;
    bif.req1 = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd0 = '0;
    exp_rd1 = '0;
  endtask

  // Single access from one port; cycle 0 is the current (IDLE) cycle.
  task automatic access(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp);
    int last;
    if (p == 0) begin
      bif.req0 = 1'b1; bif.we0 = we; bif.addr0 = a; bif.wdata0 = wd;
    end else begin
      bif.req1 = 1'b1; bif.we1 = we; bif.addr1 = a; bif.wdata1 = wd;
    end
    last = we ? 2 : RD_LAT + 3;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (!we && c == RD_LAT + 2) begin
        if (p == 0) exp_rd0 = exp;
        else        exp_rd1 = exp;
      end
      chk("gnt0",    bif.gnt0,    p == 0 && c == 1);
      chk("gnt1",    bif.gnt1,    p == 1 && c == 1);
      chk("wren",    bif.mem_wren, we && c == 1);
      chk("rvalid0", bif.rvalid0, !we && p == 0 && c == RD_LAT + 2);
      chk("rvalid1", bif.rvalid1, !we && p == 1 && c == RD_LAT + 2);
      chk("busy",    busy,        c != last);
      chk("addr",    bif.mem_address, a);
      chk("rdata0",  bif.rdata0,  exp_rd0);
      chk("rdata1",  bif.rdata1,  exp_rd1);
      if (c == 1) begin
        if (we) chk("wdata", bif.mem_data, wd);
        drop_reqs();
      end
    end
  endtask

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];
  int   exp_owner[4];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
    for (int i = 0; i < RD_LAT; i++) begin pv[i] = 1'b0; pa[i] = '0; end
    garbage = 32'hBAD0_BAD0;

    vecs[0]  = '{0, 1'b1, 12'h004, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 1'b0, 12'h004, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1, 1'b0, 12'h004, 32'h0,        32'hDEADBEEF};
    vecs[3]  = '{1, 1'b1, 12'h020, 32'hCAFEF00D, 32'h0};
    vecs[4]  = '{1, 1'b0, 12'h020, 32'h0,        32'hCAFEF00D};
    vecs[5]  = '{0, 1'b0, 12'h010, 32'h0,        32'h10000010};
    vecs[6]  = '{0, 1'b1, 12'h010, 32'h12345678, 32'h0};
    vecs[7]  = '{1, 1'b0, 12'h010, 32'h0,        32'h12345678};
    vecs[8]  = '{1, 1'b1, 12'hFFF, 32'hA5A5A5A5, 32'h0};
    vecs[9]  = '{0, 1'b0, 12'hFFF, 32'h0,        32'hA5A5A5A5};
    vecs[10] = '{0, 1'b0, 12'h0FF, 32'h0,        32'h100000FF};
`ifdef DMEM_ARB_RR_EN
    exp_owner = '{0, 1, 0, 1};
`else
    exp_owner = '{0, 0, 0, 0};
`endif

    // Reset held with both ports requesting.
    rst_n = 1'b0;
    bif.req0 = 1'b1; bif.we0 = 1'b1; bif.addr0 = 12'h123; bif.wdata0 = 32'h55;
    bif.req1 = 1'b1; bif.we1 = 1'b0; bif.addr1 = 12'h456; bif.wdata1 = 32'h66;
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt",    {bif.gnt0, bif.gnt1}, 0);
      chk("rst_rvalid", {bif.rvalid0, bif.rvalid1}, 0);
      chk("rst_rdata",  {bif.rdata0, bif.rdata1}, 0);
      chk("rst_mem",    {bif.mem_address, bif.mem_data}, 0);
      chk("rst_wren",   bif.mem_wren, 0);
      chk("rst_busy",   busy, 0);
    end
    drop_reqs();
    rst_n = 1'b1;
    exp_rd0 = '0;
    exp_rd1 = '0;

    // Directed single accesses.
    for (int i = 0; i < 11; i++)
      access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

    // Simultaneous reads after reset: port 0 first, then port 1.
    reset_pulse();
    bif.req0 = 1'b1; bif.we0 = 1'b0; bif.addr0 = 12'h010;
    bif.req1 = 1'b1; bif.we1 = 1'b0; bif.addr1 = 12'h020;
    for (int c = 1; c <= 2 * RD_LAT + 6; c++) begin
      @(negedge clk);
      if (c == RD_LAT + 2)     exp_rd0 = 32'h12345678;
      if (c == 2 * RD_LAT + 5) exp_rd1 = 32'hCAFEF00D;
      chk("sim_gnt0",    bif.gnt0,    c == 1);
      chk("sim_gnt1",    bif.gnt1,    c == RD_LAT + 4);
      chk("sim_rvalid0", bif.rvalid0, c == RD_LAT + 2);
      chk("sim_rvalid1", bif.rvalid1, c == 2 * RD_LAT + 5);
      chk("sim_busy",    busy,        c != RD_LAT + 3 && c != 2 * RD_LAT + 6);
      chk("sim_rdata0",  bif.rdata0,  exp_rd0);
      chk("sim_rdata1",  bif.rdata1,  exp_rd1);
      if (c == 1)          bif.req0 = 1'b0;
      if (c == RD_LAT + 4) bif.req1 = 1'b0;
    end

    // Both ports requesting continuously for four grants.
    reset_pulse();
    bif.req0 = 1'b1; bif.req1 = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      if (bif.gnt0 || bif.gnt1) begin
        chk("arb_both_gnt", bif.gnt0 && bif.gnt1, 0);
        chk("arb_owner", bif.gnt1, exp_owner[n]);
        n++;
        if (n == 4) drop_reqs();
      end
    end
    chk("arb_grants", n, 4);
    drop_reqs();
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    chk("arb_idle", busy, 0);
    exp_rd0 = 32'h12345678;
`ifdef DMEM_ARB_RR_EN
    exp_rd1 = 32'hCAFEF00D;
`else
    exp_rd1 = 32'h0;
`endif
    chk("arb_rdata0", bif.rdata0, exp_rd0);
    chk("arb_rdata1", bif.rdata1, exp_rd1);

    // Reset during WAIT abandons the read.
    bif.req0 = 1'b1; bif.we0 = 1'b0; bif.addr0 = 12'h0FF;
    @(negedge clk);
    chk("abort_gnt0", bif.gnt0, 1);
    bif.req0 = 1'b0;
    @(negedge clk);
    chk("abort_wait_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy",   busy, 0);
    chk("abort_rvalid", bif.rvalid0, 0);
    chk("abort_wren",   bif.mem_wren, 0);
    chk("abort_rdata0", bif.rdata0, 0);
    rst_n = 1'b1;
    exp_rd0 = '0;
    exp_rd1 = '0;
    repeat (RD_LAT + 3) begin
      @(negedge clk);
      chk("abort_no_rvalid", {bif.rvalid0, bif.rvalid1}, 0);
      chk("abort_idle", busy, 0);
    end
    access(0, 1'b0, 12'h0FF, 32'h0, 32'h100000FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
